// File: rtl/alu_sat_stage.sv
// Saturating output stage behind the 16-bit adder: clamps ADD/SUB/PADDSB results,
// holds one result in a valid/ready register and commits Z/V/N flags on handoff.
module alu_sat_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] sum,
    input  logic        padd,
    input  logic        sub,
    input  logic        red,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n
);

    localparam int unsigned W       = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = W / NIB_W;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned FZ      = 2;
    localparam int unsigned FV      = 1;
    localparam int unsigned FN      = 0;

    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       result_q, result_d;
    logic [FLAGS_W-1:0] pend_q, pend_d;
    logic [FLAGS_W-1:0] mask_q, mask_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;

    logic               op_red;
    logic               op_sub;
    logic [W-1:0]       b_eff;
    logic               word_ovf;
    logic [W-1:0]       word_sat;
    logic [W-1:0]       nib_sat;
    logic [W-1:0]       sat_res;
    logic [FLAGS_W-1:0] new_pend;
    logic [FLAGS_W-1:0] new_mask;
    logic               capture;
    logic               handoff;

    // Decode priority padd > red > sub > add; saturate the incoming sum.
    always_comb begin
        op_red   = !padd && red;
        op_sub   = !padd && !red && sub;
        b_eff    = op_sub ? ~b : b;
        word_ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
        word_sat = sum;
        if (word_ovf) begin
            word_sat = a[W-1] ? 16'h8000 : 16'h7FFF;
        end

        nib_sat = sum;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if ((a[NIB_W*i+3] == b[NIB_W*i+3]) && (sum[NIB_W*i+3] != a[NIB_W*i+3])) begin
                nib_sat[NIB_W*i +: NIB_W] = a[NIB_W*i+3] ? 4'h8 : 4'h7;
            end
        end

        sat_res  = word_sat;
        new_pend = '0;
        new_mask = '0;
        if (padd) begin
            sat_res = nib_sat;
        end else if (op_red) begin
            sat_res      = sum;
            new_pend[FZ] = (sum == '0);
            new_mask     = 3'b100;
        end else begin
            new_pend[FZ] = (word_sat == '0);
            new_pend[FV] = word_ovf;
            new_pend[FN] = word_sat[W-1];
            new_mask     = 3'b111;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign handoff  = out_valid_q && out_ready && !flush;
    assign capture  = in_valid && in_ready && !flush;

    // Next-state for the pipeline register and the architectural flags.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        pend_d      = pend_q;
        mask_d      = mask_q;
        flags_d     = flags_q;

        if (handoff) begin
            for (int i = 0; i < int'(FLAGS_W); i++) begin
                if (mask_q[i]) begin
                    flags_d[i] = pend_q[i];
                end
            end
        end

        if (capture) begin
            out_valid_d = 1'b1;
            result_d    = sat_res;
            pend_d      = new_pend;
            mask_d      = new_mask;
        end else if (handoff || flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flags_q[FZ];
    assign flag_v    = flags_q[FV];
    assign flag_n    = flags_q[FN];

endmodule

// File: tb/tb_alu_sat_stage.sv
// Bench for alu_sat_stage: driver pushes arithmetic-model expectations on capture,
// a negedge monitor tracks handoff/flush/reset and compares every output.
module tb_alu_sat_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, sum;
    logic        padd, sub, red, flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z, flag_v, flag_n;

    always #5 clk = ~clk;

    alu_sat_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sum(sum), .padd(padd), .sub(sub), .red(red),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  pend;   // {z, v, n}
        logic [2:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   push_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int sx16(input logic [15:0] v);
        return v[15] ? int'(v) - 65536 : int'(v);
    endfunction

    // Reference: signed math with clamping, independent of the adder's raw sum.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic [15:0] ms, input logic mp,
                                   input logic msu, input logic mr);
        exp_t e;
        int   t;
        logic v;
        e = '0;
        if (mp) begin
            for (int i = 0; i < 4; i++) begin
                t = sx4(ma[4*i +: 4]) + sx4(mb[4*i +: 4]);
                if (t > 7)  t = 7;
                if (t < -8) t = -8;
                e.res[4*i +: 4] = 4'(t);
            end
        end else if (mr) begin
            e.res  = ms;
            e.mask = 3'b100;
            e.pend = {(ms == 16'h0), 2'b00};
        end else begin
            t = msu ? sx16(ma) - sx16(mb) : sx16(ma) + sx16(mb);
            v = (t > 32767) || (t < -32768);
            if (t > 32767)  t = 32767;
            if (t < -32768) t = -32768;
            e.res  = 16'(t);
            e.mask = 3'b111;
            e.pend = {(e.res == 16'h0), v, e.res[15]};
        end
        return e;
    endfunction

    function automatic logic [15:0] gen_sum(input logic [15:0] ga, input logic [15:0] gb,
                                            input logic gp, input logic gsu, input logic gr);
        logic [15:0] s;
        s = 16'h0;
        if (gp) begin
            for (int i = 0; i < 4; i++) s[4*i +: 4] = ga[4*i +: 4] + gb[4*i +: 4];
        end else if (gr) begin
            s = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
        end else if (gsu) begin
            s = ga - gb;
        end else begin
            s = ga + gb;
        end
        return s;
    endfunction

    task automatic issue(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] is, input logic ip, input logic isu,
                         input logic ir, input logic ifl, input logic ior, input logic irst);
        @(posedge clk);
        #1;
        in_valid = iv; a = ia; b = ib; sum = is;
        padd = ip; sub = isu; red = ir; flush = ifl; out_ready = ior; rst = irst;
        #2;
        if (iv && in_ready && !ifl && !irst) begin
            exp_q.push_back(model(ia, ib, is, ip, isu, ir));
            push_cnt++;
        end
    endtask

    task automatic op(input int kind, input logic [15:0] oa, input logic [15:0] ob,
                      input logic [15:0] os, input logic ior);
        issue(1'b1, oa, ob, os, kind == 2, kind == 1, kind == 3, 1'b0, ior, 1'b0);
    endtask

    task automatic idle(input logic ior);
        issue(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, ior, 1'b0);
    endtask

    task automatic neg_chk(input string name, input logic [31:0] act_sel, input logic [31:0] expv);
        chk(name, act_sel, expv);
    endtask

    // Monitor: compare against the tracked model, then advance it for the coming edge.
    logic        mv = 1'b0;
    logic [15:0] mres = 16'h0;
    logic [2:0]  mflags = 3'b000;
    bit          started = 1'b0;
    int          seen_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
            chk("result", 32'(result), 32'(mres));
            chk("flags_zvn", 32'({flag_z, flag_v, flag_n}), 32'(mflags));
        end
        if (rst) begin
            exp_q.delete();
            mv       = 1'b0;
            mres     = 16'h0;
            mflags   = 3'b000;
            seen_cnt = push_cnt;
            started  = 1'b1;
        end else begin
            if (mv && exp_q.size() > 0) begin
                if (out_ready && !flush) begin
                    for (int i = 0; i < 3; i++)
                        if (exp_q[0].mask[i]) mflags[i] = exp_q[0].pend[i];
                    void'(exp_q.pop_front());
                end else if (flush) begin
                    void'(exp_q.pop_front());
                end
            end
            if (push_cnt != seen_cnt && exp_q.size() > 0) begin
                mres     = exp_q[$].res;
                seen_cnt = push_cnt;
            end
            mv = (exp_q.size() != 0);
        end
    end

    logic [15:0] corners [8];
    logic [15:0] ra, rb;
    logic        rp, rsu, rr;

    initial begin
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                    16'hFFFF, 16'h7777, 16'h8888, 16'h1234};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sum = '0;
        padd = 1'b0; sub = 1'b0; red = 1'b0; flush = 1'b0; out_ready = 1'b0;
        issue(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        neg_chk("reset_valid", 32'(out_valid), 32'h0);
        neg_chk("reset_result", 32'(result), 32'h0);

        // Word saturation and flags
        op(0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("add_sat_res", 32'(result), 32'h7FFF);
        idle(1'b1);
        @(negedge clk); neg_chk("add_sat_flags", 32'({flag_z, flag_v, flag_n}), 32'b010);
        op(1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("sub_sat_res", 32'(result), 32'h8000);
        idle(1'b1);
        @(negedge clk); neg_chk("sub_sat_flags", 32'({flag_z, flag_v, flag_n}), 32'b011);
        op(0, 16'h0005, 16'hFFFB, 16'h0000, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("add_zero_res", 32'(result), 32'h0000);
        idle(1'b1);
        @(negedge clk); neg_chk("add_zero_flags", 32'({flag_z, flag_v, flag_n}), 32'b100);

        // Nibble saturation leaves flags alone
        op(2, 16'h7777, 16'h1111, 16'h8888, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("padd_pos_res", 32'(result), 32'h7777);
        op(2, 16'h8888, 16'h8888, 16'h0000, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("padd_neg_res", 32'(result), 32'h8888);
        op(2, 16'h1234, 16'h1111, 16'h2345, 1'b1); idle(1'b1);
        @(negedge clk); neg_chk("padd_none_res", 32'(result), 32'h2345);
        idle(1'b1);
        @(negedge clk); neg_chk("padd_flags", 32'({flag_z, flag_v, flag_n}), 32'b100);

        // Back-pressure, then simultaneous handoff and capture
        op(0, 16'h0003, 16'h0004, 16'h0007, 1'b1);
        for (int i = 0; i < 3; i++) begin
            op(0, 16'h0010, 16'h0020, 16'h0030, 1'b0);
            @(negedge clk);
            neg_chk("stall_in_ready", 32'(in_ready), 32'h0);
            neg_chk("stall_result", 32'(result), 32'h0007);
            neg_chk("stall_flags", 32'({flag_z, flag_v, flag_n}), 32'b100);
        end
        op(0, 16'h0010, 16'h0020, 16'h0030, 1'b1); idle(1'b1);
        @(negedge clk);
        neg_chk("bp_second_res", 32'(result), 32'h0030);
        neg_chk("bp_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);
        idle(1'b1);

        // Flush of a held overflowing entry
        op(0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0); idle(1'b0);
        issue(1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        neg_chk("flush_valid", 32'(out_valid), 32'h0);
        neg_chk("flush_result", 32'(result), 32'h7FFF);
        neg_chk("flush_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);

        // Reset mid-stall
        op(1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1); idle(1'b1);
        op(0, 16'h0001, 16'h0001, 16'h0002, 1'b0); idle(1'b0);
        @(negedge clk);
        neg_chk("pre_rst_n", 32'(flag_n), 32'h1);
        issue(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        neg_chk("rst_valid", 32'(out_valid), 32'h0);
        neg_chk("rst_result", 32'(result), 32'h0);
        neg_chk("rst_flags", 32'({flag_z, flag_v, flag_n}), 32'b000);

        // Randomized traffic with corner operands, stalls, flushes and resets
        for (int n = 0; n < 800; n++) begin
            ra  = (($urandom % 4) == 0) ? corners[$urandom % 8] : 16'($urandom);
            rb  = (($urandom % 4) == 0) ? corners[$urandom % 8] : 16'($urandom);
            rp  = (($urandom % 4) == 0);
            rr  = (($urandom % 3) == 0);
            rsu = 1'($urandom);
            issue((($urandom % 4) != 0), ra, rb,
                  gen_sum(ra, rb, rp, !rp && !rr && rsu, !rp && rr),
                  rp, rsu, rr, (($urandom % 20) == 0), (($urandom % 10) < 7),
                  (($urandom % 100) == 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sat_stage.md
# alu_sat_stage

Registered output stage directly downstream of the 16-bit adder (`adder16`) in the ALU. It consumes the raw adder sum plus the original operands and applies signed saturation: whole-word for ADD/SUB, per-nibble for PADDSB, none for RED. It holds the result in a single-entry valid/ready pipeline register and commits the Z/V/N flags when a result is handed downstream. Flush support lets branch mispredicts discard an in-flight result without corrupting the flags.

## Interface
- No parameters; the datapath is fixed at 16 bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the sum/operand/op bundle is valid this cycle.
- `in_ready` out 1: the stage can accept a bundle this cycle.
- `a` in 16: operand A, as presented to the adder.
- `b` in 16: operand B, as presented to the adder, before any inversion for subtraction.
- `sum` in 16: raw adder output for (a, b, padd, sub, red).
- `padd` in 1: parallel nibble add.
- `sub` in 1: subtract; ignored when `padd` or `red` is 1.
- `red` in 1: reduction; ignored when `padd` is 1.
- `flush` in 1: discard the held entry and any entry offered this cycle.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer accepts `result` this cycle.
- `result` out 16: saturated result, registered.
- `flag_z`, `flag_v`, `flag_n` out 1 each: committed flags, registered.

## Operation
- Op decode priority: padd > red > sub > add.
  - ADD: b' = b.
  - SUB: b' = ~b.
- ADD/SUB saturation:
  - Overflow ovf = (a[15] == b'[15]) && (sum[15] != a[15]).
  - If ovf is 1: result = 16'h7FFF when a[15] = 0, else 16'h8000.
  - Otherwise result = sum.
- PADDSB saturation, for each nibble i in 0..3 independently:
  - Overflow when a_i[3] == b_i[3] && sum_i[3] != a_i[3].
  - On overflow the nibble becomes 4'h7 (a_i[3] = 0) or 4'h8 (a_i[3] = 1); otherwise the nibble is sum_i.
- RED: result = sum, unmodified.
- Flags computed per entry and stored alongside it (pending flags):
  - ADD/SUB: Z = (result == 0), V = ovf, N = result[15].
  - RED: Z updated only.
  - PADDSB: no flag updated.
  - Each entry carries a 3-bit flag write mask.
- Architectural flags update only at handoff (out_valid && out_ready && !flush). Masked bits take the pending values; other bits hold.
- Pipeline register:
  - in_ready = !out_valid || out_ready.
  - Capture when in_valid && in_ready && !flush. Set out_valid; load result, pending flags and mask.
  - If handoff happens with no capture, clear out_valid.
  - Simultaneous handoff and capture: commit flags from the old entry; the new entry replaces it; out_valid stays 1.
- flush:
  - Next cycle out_valid = 0.
  - No capture and no flag commit that cycle, even if out_ready = 1.
  - result register holds its old value.
  - Architectural flags unchanged.
- Back-pressure: while out_valid && !out_ready, result, pending flags and architectural flags hold; in_ready = 0; the bundle on the inputs is not consumed.

## Timing
- Reset (rst = 1 at a clock edge): out_valid = 0, result = 16'h0000, flag_z = flag_v = flag_n = 0, pending mask = 0. rst overrides flush and capture.
- Latency: a bundle accepted at edge k appears on result/out_valid after edge k. Flags from it appear after the edge at which it is handed off.
- Throughput: 1 per cycle with out_ready held at 1.
- in_ready is combinational from out_valid and out_ready. No combinational path from in_valid or sum to any output.
- Reset mid-stall discards the held entry; flags return to 0.

## Test plan
- ADD a=16'h7FFF, b=16'h0001, sum=16'h8000, out_ready=1 -> next cycle result=16'h7FFF, out_valid=1; after handoff edge Z=0, V=1, N=0.
- SUB a=16'h8000, b=16'h0001, sum=16'h7FFF -> result=16'h8000; after handoff V=1, N=1, Z=0. Then ADD a=16'h0005, b=16'hFFFB, sum=16'h0000 -> result=16'h0000; after handoff Z=1, V=0, N=0.
- PADDSB a=16'h7777, b=16'h1111, sum=16'h8888 -> result=16'h7777. Then a=16'h8888, b=16'h8888, sum=16'h0000 -> result=16'h8888. a=16'h1234, b=16'h1111, sum=16'h2345 -> 16'h2345. In all cases flags unchanged from their prior values.
- Back-pressure: capture ADD 16'h0003+16'h0004; hold out_ready=0 for 3 cycles while in_valid=1 with a second bundle -> in_ready=0, result=16'h0007 held, flags unchanged. Raise out_ready -> flags commit (Z=0, N=0, V=0) and the second bundle is captured on the same edge.
- Flush: entry ADD producing V=1 held with out_ready=0; assert flush with in_valid=1 -> next cycle out_valid=0, flags unchanged, offered bundle dropped.
- Reset: assert rst while out_valid=1 and flag_n=1 -> next cycle out_valid=0, result=16'h0000, all flags 0.
